// File: rtl/mergesort_ctrl_if.sv
// Handshake and scratch-memory bundle between the merge-sort controller and its environment.
interface mergesort_ctrl_if #(
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned WORD_W = 4 * DATA_W;

    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [WORD_W-1:0] mergelist_out;
    logic              out_valid;
    logic              out_ready;

    logic              busy;
    logic              done;

    // Controller side
    modport master (
        input  start, in_valid, in_data, rd_data_a, rd_data_b, out_ready,
        output in_ready, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
               mergelist_out, out_valid, busy, done
    );

    // Environment side: producer, scratch memory and consumer
    modport slave (
        output start, in_valid, in_data, rd_data_a, rd_data_b, out_ready,
        input  in_ready, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
               mergelist_out, out_valid, busy, done
    );
endinterface

// File: rtl/mergesort_ctrl.sv
// Bottom-up merge sort of 16 elements using an external 32-entry scratch memory
// (bank A = 0..15, bank B = 16..31); result is unloaded as four packed words.
module mergesort_ctrl #(
    parameter int unsigned DATA_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    mergesort_ctrl_if.master bus
);
    localparam int unsigned PTR_W  = 5;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned WORD_W = 4 * DATA_W;
    localparam int unsigned HALF_W = 2 * DATA_W;

    localparam logic [PTR_W-1:0] LAST_K = PTR_W'(15);
    localparam logic [PTR_W-1:0] W_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] W_LAST = PTR_W'(8);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MERGE,
        PASS_END,
        OUT_RD0,
        OUT_RD1,
        OUT_HOLD
    } state_t;

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  w_q, w_d;
    logic [PTR_W-1:0]  base_q, base_d;
    logic [PTR_W-1:0]  i_q, i_d;
    logic [PTR_W-1:0]  j_q, j_d;
    logic [PTR_W-1:0]  k_q, k_d;
    logic              src_q, src_d;
    logic [1:0]        n_q, n_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              done_q, done_d;

    logic              in_ready;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [PTR_W-1:0]  rd_addr_a;
    logic [PTR_W-1:0]  rd_addr_b;
    logic              out_valid;

    logic [PTR_W-1:0]  w2;
    logic [PTR_W-1:0]  left_end;
    logic [PTR_W-1:0]  right_end;
    logic [PTR_W-1:0]  k_inc;
    logic              left_ex;
    logic              right_ex;
    logic              take_left;

    // Run boundaries and the stable, unsigned left/right selection
    always_comb begin
        w2        = PTR_W'(w_q << 1);
        left_end  = PTR_W'(base_q + w_q);
        right_end = PTR_W'(base_q + w2);
        k_inc     = PTR_W'(k_q + W_ONE);
        left_ex   = (i_q == left_end);
        right_ex  = (j_q == right_end);
        take_left = right_ex || (!left_ex && (bus.rd_data_a <= bus.rd_data_b));
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            w_q    <= W_ONE;
            base_q <= '0;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            src_q  <= 1'b0;
            n_q    <= '0;
            hold_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            w_q    <= w_d;
            base_q <= base_d;
            i_q    <= i_d;
            j_q    <= j_d;
            k_q    <= k_d;
            src_q  <= src_d;
            n_q    <= n_d;
            hold_q <= hold_d;
            done_q <= done_d;
        end
    end

    // Next-state, pointer updates and memory/handshake strobes
    always_comb begin
        state_nxt = state;
        w_d       = w_q;
        base_d    = base_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        src_d     = src_q;
        n_d       = n_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        out_valid = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = LOAD;
                    k_d       = '0;
                end
            end

            LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = {1'b0, k_q[IDX_W-1:0]};
                    wr_data = bus.in_data;
                    k_d     = k_inc;
                    if (k_q == LAST_K) begin
                        state_nxt = MERGE;
                        w_d       = W_ONE;
                        src_d     = 1'b0;
                        base_d    = '0;
                        i_d       = '0;
                        j_d       = W_ONE;
                        k_d       = '0;
                    end
                end
            end

            MERGE: begin
                rd_addr_a = {src_q, i_q[IDX_W-1:0]};
                rd_addr_b = {src_q, j_q[IDX_W-1:0]};
                wr_en     = 1'b1;
                wr_addr   = {~src_q, k_q[IDX_W-1:0]};
                wr_data   = take_left ? bus.rd_data_a : bus.rd_data_b;
                k_d       = k_inc;
                if (take_left) begin
                    i_d = PTR_W'(i_q + W_ONE);
                end else begin
                    j_d = PTR_W'(j_q + W_ONE);
                end
                // Pair of runs complete: restart both pointers on the next pair
                if (k_inc == right_end) begin
                    base_d = right_end;
                    i_d    = right_end;
                    j_d    = PTR_W'(right_end + w_q);
                end
                if (k_q == LAST_K) begin
                    state_nxt = PASS_END;
                end
            end

            PASS_END: begin
                src_d  = ~src_q;
                base_d = '0;
                i_d    = '0;
                j_d    = w2;
                k_d    = '0;
                if (w_q == W_LAST) begin
                    // Four passes alternate banks, so the result sits in bank A
                    w_d       = W_ONE;
                    n_d       = '0;
                    state_nxt = OUT_RD0;
                end else begin
                    w_d       = w2;
                    state_nxt = MERGE;
                end
            end

            OUT_RD0: begin
                rd_addr_a = {1'b0, n_q, 2'b00};
                rd_addr_b = {1'b0, n_q, 2'b01};
                hold_d[WORD_W-1 -: HALF_W] = {bus.rd_data_a, bus.rd_data_b};
                state_nxt = OUT_RD1;
            end

            OUT_RD1: begin
                rd_addr_a = {1'b0, n_q, 2'b10};
                rd_addr_b = {1'b0, n_q, 2'b11};
                hold_d[HALF_W-1:0] = {bus.rd_data_a, bus.rd_data_b};
                state_nxt = OUT_HOLD;
            end

            OUT_HOLD: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    n_d = 2'(n_q + 2'd1);
                    if (n_q == 2'd3) begin
                        state_nxt = IDLE;
                        done_d    = 1'b1;
                    end else begin
                        state_nxt = OUT_RD0;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.in_ready      = in_ready;
    assign bus.wr_en         = wr_en;
    assign bus.wr_addr       = wr_addr;
    assign bus.wr_data       = wr_data;
    assign bus.rd_addr_a     = rd_addr_a;
    assign bus.rd_addr_b     = rd_addr_b;
    assign bus.out_valid     = out_valid;
    assign bus.mergelist_out = hold_q;
    assign bus.busy          = (state != IDLE);
    assign bus.done          = done_q;

endmodule

// File: tb/tb_mergesort_ctrl.sv
// Self-checking bench for mergesort_ctrl: scratch memory model, per-pass merge
// reference and final sorted-word checks, including stall and reset-abort cases.
module tb_mergesort_ctrl;
    localparam int unsigned DATA_W = 8;
    localparam int          NVEC   = 10;

    typedef struct packed {
        logic [127:0] din;        // element e at din[127-8e -: 8]
        logic [127:0] exp;        // word n at exp[127-32n -: 32]
        int           gaps;       // insert idle cycles between load beats
        int           stall_word; // word held with out_ready=0 (4 = none)
        int           stall_cyc;
        int           abort_pass; // -1 = run to completion
        int           abort_cyc;
    } vec_t;

    logic clock = 1'b0;
    logic reset;

    mergesort_ctrl_if #(.DATA_W(DATA_W)) bus ();

    mergesort_ctrl #(.DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // 32 x 8 scratch memory: combinational reads, synchronous write
    logic [7:0] mem [32];
    assign bus.rd_data_a = mem[bus.rd_addr_a];
    assign bus.rd_data_b = mem[bus.rd_addr_b];
    always @(posedge clock) if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] cur [16];
    logic [7:0] nxt [16];
    int         ea  [16];
    int         eb  [16];
    vec_t       vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: stable merge of adjacent runs of width w, cur -> nxt, with
    // the element each non-exhausted pointer refers to at every output step.
    task automatic model_pass(input int w);
        int k, i, j;
        bit lok, rok;
        k = 0;
        for (int base = 0; base < 16; base += 2 * w) begin
            i = base;
            j = base + w;
            for (int o = 0; o < 2 * w; o++) begin
                lok   = (i < base + w);
                rok   = (j < base + 2 * w);
                ea[k] = lok ? i : -1;
                eb[k] = rok ? j : -1;
                if (lok && (!rok || cur[i] <= cur[j])) begin
                    nxt[k] = cur[i];
                    i++;
                end else begin
                    nxt[k] = cur[j];
                    j++;
                end
                k++;
            end
        end
    endtask

    function automatic logic [127:0] sorted_of(input logic [127:0] din);
        logic [7:0]   a [16];
        logic [7:0]   t;
        int           j;
        logic [127:0] r;
        for (int e = 0; e < 16; e++) a[e] = din[127-8*e -: 8];
        for (int e = 1; e < 16; e++) begin
            t = a[e];
            j = e - 1;
            while (j >= 0 && a[j] > t) begin
                a[j+1] = a[j];
                j--;
            end
            a[j+1] = t;
        end
        for (int e = 0; e < 16; e++) r[127-8*e -: 8] = a[e];
        return r;
    endfunction

    task automatic do_abort();
        logic [7:0] snap [32];
        int diff;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        snap  = mem;
        reset = 1'b0;
        #1;
        check("abort_strobes", 64'({bus.wr_en, bus.busy, bus.out_valid, bus.in_ready, bus.done}), 64'(0));
        check("abort_buses", 64'({bus.wr_addr, bus.wr_data, bus.rd_addr_a, bus.rd_addr_b, bus.mergelist_out}), 64'(0));
        repeat (2) @(negedge clock);
        diff = 0;
        for (int e = 0; e < 32; e++) if (mem[e] !== snap[e]) diff++;
        check("abort_no_write", 64'(diff), 64'(0));
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("abort_idle", 64'({bus.busy, bus.in_ready, bus.wr_en, bus.done}), 64'(0));
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0]  d [16];
        logic [31:0] ew;
        int          idx, cyc, src;
        logic        vld;
        for (int e = 0; e < 16; e++) d[e] = v.din[127-8*e -: 8];

        // Start request from IDLE
        @(negedge clock);
        bus.start = 1'b1;
        #1;
        check("pre_start_idle", 64'({bus.busy, bus.in_ready}), 64'(0));

        // Load: write address follows the accepted count
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 100) begin
            @(negedge clock);
            bus.start    = 1'b0;
            vld          = (v.gaps != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_valid = vld;
            bus.in_data  = vld ? d[idx] : 8'($urandom);
            #1;
            if (vld)
                check("load_beat", 64'({bus.in_ready, bus.busy, bus.wr_en, bus.wr_addr, bus.wr_data}),
                      64'({1'b1, 1'b1, 1'b1, 5'(idx), d[idx]}));
            else
                check("load_idle", 64'({bus.in_ready, bus.busy, bus.wr_en}), 64'(3'b110));
            if (vld) idx++;
            cyc++;
        end

        // Four merge passes, each 16 write cycles plus one pass-end cycle
        for (int e = 0; e < 16; e++) cur[e] = d[e];
        for (int p = 0; p < 4; p++) begin
            model_pass(1 << p);
            src = p % 2;
            for (int c = 0; c < 16; c++) begin
                @(negedge clock);
                if (v.abort_pass == p && v.abort_cyc == c) begin
                    do_abort();
                    return;
                end
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = 8'($urandom);
                bus.start    = 1'($urandom_range(0, 1));
                #1;
                check("merge_write", 64'({bus.in_ready, bus.busy, bus.out_valid, bus.wr_en, bus.wr_addr, bus.wr_data}),
                      64'({1'b0, 1'b1, 1'b0, 1'b1, 5'((1 - src) * 16 + c), nxt[c]}));
                if (ea[c] >= 0) check("merge_rd_a", 64'(bus.rd_addr_a), 64'(src * 16 + ea[c]));
                if (eb[c] >= 0) check("merge_rd_b", 64'(bus.rd_addr_b), 64'(src * 16 + eb[c]));
            end
            @(negedge clock);
            bus.start = 1'($urandom_range(0, 1));
            #1;
            check("pass_end", 64'({bus.wr_en, bus.busy, bus.in_ready, bus.out_valid}), 64'(4'b0100));
            for (int e = 0; e < 16; e++) cur[e] = nxt[e];
        end

        // Unload four words
        bus.in_valid = 1'b0;
        ew = '0;
        for (int n = 0; n < 4; n++) begin
            ew = v.exp[127-32*n -: 32];
            @(negedge clock);
            bus.out_ready = 1'b1;
            bus.start     = 1'b0;
            #1;
            check("out_rd0", 64'({bus.out_valid, bus.wr_en, bus.busy, bus.rd_addr_a, bus.rd_addr_b}),
                  64'({1'b0, 1'b0, 1'b1, 5'(4 * n), 5'(4 * n + 1)}));
            @(negedge clock);
            #1;
            check("out_rd1", 64'({bus.out_valid, bus.wr_en, bus.busy, bus.rd_addr_a, bus.rd_addr_b}),
                  64'({1'b0, 1'b0, 1'b1, 5'(4 * n + 2), 5'(4 * n + 3)}));
            if (n == v.stall_word) begin
                for (int s = 0; s < v.stall_cyc; s++) begin
                    @(negedge clock);
                    bus.out_ready = 1'b0;
                    bus.start     = 1'b1;
                    #1;
                    check("out_stall", 64'({bus.out_valid, bus.busy, bus.mergelist_out}), 64'({1'b1, 1'b1, ew}));
                end
            end
            @(negedge clock);
            bus.out_ready = 1'b1;
            bus.start     = 1'b0;
            #1;
            check("out_word", 64'({bus.out_valid, bus.wr_en, bus.mergelist_out}), 64'({1'b1, 1'b0, ew}));
        end

        @(negedge clock);
        #1;
        check("done_high", 64'({bus.done, bus.busy, bus.out_valid}), 64'(3'b100));
        @(negedge clock);
        #1;
        check("done_pulse_hold", 64'({bus.done, bus.busy, bus.mergelist_out}), 64'({1'b0, 1'b0, ew}));
    endtask

    initial begin
        logic [127:0] t;

        vecs[0] = '{din: 128'h0F0E0D0C0B0A09080706050403020100,
                    exp: 128'h000102030405060708090A0B0C0D0E0F,
                    gaps: 0, stall_word: 4, stall_cyc: 0, abort_pass: -1, abort_cyc: -1};
        vecs[1] = '{din: {16{8'h5A}}, exp: {16{8'h5A}},
                    gaps: 0, stall_word: 4, stall_cyc: 0, abort_pass: -1, abort_cyc: -1};
        vecs[2] = '{din: 128'hFF030103010301030103010301030100,
                    exp: 128'h00010101010101010303030303_0303FF,
                    gaps: 1, stall_word: 4, stall_cyc: 0, abort_pass: -1, abort_cyc: -1};
        t = 128'h3CA107FF005E5E1288_01C37F40229B10;
        vecs[3] = '{din: t, exp: sorted_of(t),
                    gaps: 1, stall_word: 1, stall_cyc: 10, abort_pass: -1, abort_cyc: -1};
        for (int e = 0; e < 16; e++) t[127-8*e -: 8] = 8'($urandom);
        vecs[4] = '{din: t, exp: '0,
                    gaps: 0, stall_word: 4, stall_cyc: 0, abort_pass: 1, abort_cyc: 5};
        for (int v = 5; v < NVEC; v++) begin
            for (int e = 0; e < 16; e++)
                t[127-8*e -: 8] = (v % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            vecs[v] = '{din: t, exp: sorted_of(t),
                        gaps: int'($urandom_range(0, 1)), stall_word: int'($urandom_range(0, 4)),
                        stall_cyc: int'($urandom_range(1, 4)), abort_pass: -1, abort_cyc: -1};
        end

        for (int e = 0; e < 32; e++) mem[e] = 8'h00;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b0;

        // Held in reset with requests present: everything quiet
        repeat (2) @(negedge clock);
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("reset_strobes", 64'({bus.in_ready, bus.wr_en, bus.out_valid, bus.busy, bus.done}), 64'(0));
        check("reset_buses", 64'({bus.mergelist_out, bus.wr_addr, bus.wr_data, bus.rd_addr_a, bus.rd_addr_b}), 64'(0));
        @(negedge clock);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("idle_after_reset", 64'({bus.busy, bus.in_ready, bus.done}), 64'(0));

        for (int v = 0; v < NVEC; v++) run_vec(vecs[v]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mergesort_ctrl.md
MERGESORT_CTRL -- requirements
Module: mergesort_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the element width in bits; the list length is fixed at 16 elements.
REQ-002 Port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port start  input  1  one-cycle request to begin a load/sort/unload sequence; honoured only in IDLE.
REQ-005 Port in_valid  input  1, in_data  input  DATA_W, in_ready  output  1: element load handshake.
REQ-006 Port rd_addr_a  output  5, rd_data_a  input  DATA_W, rd_addr_b  output  5, rd_data_b  input  DATA_W: two combinational read ports on the external 32 x DATA_W scratch memory.
REQ-007 Port wr_en  output  1, wr_addr  output  5, wr_data  output  DATA_W: synchronous write port on the same memory.
REQ-008 Port mergelist_out  output  4*DATA_W, out_valid  output  1, out_ready  input  1: sorted-word output handshake.
REQ-009 Port busy  output  1  high in every state except IDLE; done  output  1  one-cycle pulse at completion.

Function
REQ-010 The memory SHALL be treated as bank A (addresses 0-15) and bank B (addresses 16-31).
REQ-011 The FSM SHALL have states IDLE, LOAD, MERGE, PASS_END, OUT_RD0, OUT_RD1, OUT_HOLD.
REQ-012 IDLE: start=1 moves to LOAD with load count 0; start in any other state is ignored.
REQ-013 LOAD: in_ready=1; each cycle with in_valid=1 drives wr_en=1, wr_addr=count, wr_data=in_data and increments count; after the 16th accepted element, the next state is MERGE with width 1, source bank A.
REQ-014 in_valid outside LOAD SHALL be ignored; in_ready SHALL be 0 outside LOAD.
REQ-015 MERGE: bottom-up merge of adjacent runs of length w (1,2,4,8) from the source bank to the other bank, one output element written per cycle, 16 cycles per pass.
REQ-016 Per cycle: left pointer i in [base, base+w), right pointer j in [base+w, base+2w); rd_addr_a = src+i, rd_addr_b = src+j.
REQ-017 Selection: take left if right is exhausted, or if left is not exhausted and rd_data_a <= rd_data_b (unsigned compare, ties to left, sort is stable); otherwise take right.
REQ-018 The selected value SHALL be written to dst+k with wr_en=1, where k is the output index; the taken pointer advances.
REQ-019 When k reaches base+2w, base SHALL advance by 2w and the pointers reset to the new base.
REQ-020 The rd_addr value of an exhausted pointer is don't-care.
REQ-021 After k=15 is written, the next state SHALL be PASS_END (1 cycle, wr_en=0), which swaps banks and doubles w; if w was 8, the next state is OUT_RD0, otherwise MERGE.
REQ-022 Passes run A->B, B->A, A->B, B->A, so the sorted result always ends in bank A; sort latency from the LOAD exit to OUT_RD0 entry is exactly 68 cycles.
REQ-023 Output word n (0..3) SHALL be {A[4n], A[4n+1], A[4n+2], A[4n+3]}, with the lowest address in the most significant byte; the list is ascending.
REQ-024 OUT_RD0 SHALL read A[4n] and A[4n+1] into the upper half of the holding register; OUT_RD1 SHALL read A[4n+2] and A[4n+3] into the lower half; then OUT_HOLD.
REQ-025 OUT_HOLD: out_valid=1 and mergelist_out is stable until out_ready=1; on acceptance, n increments and the next state is OUT_RD0, or after word 3 the state returns to IDLE with done=1 for one cycle.
REQ-026 mergelist_out SHALL hold its last value after completion until the next sequence overwrites it.
REQ-027 wr_en SHALL be 0 in IDLE, PASS_END and all OUT states.

Reset
REQ-028 While reset=0: state IDLE, all counters and pointers 0, w=1, src=A, and in_ready, wr_en, out_valid, busy and done all 0.
REQ-029 While reset=0: mergelist_out, wr_addr, wr_data, rd_addr_a and rd_addr_b are all 0.
REQ-030 Reset asserted mid-LOAD, mid-MERGE or mid-output SHALL abort immediately without any further memory write; memory contents are not cleared.
REQ-031 After reset release, the block SHALL wait in IDLE for start.

Verification
REQ-032 Load 0x0F down to 0x00, with out_ready held at 1 -> words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F, then done pulse.
REQ-033 Load all 0x5A -> four words of 0x5A5A5A5A; continuous in_valid -> exactly 16 LOAD cycles; exactly 68 cycles from LOAD exit to OUT_RD0.
REQ-034 Load 3,1,3,1,... with 0xFF and 0x00 at ends -> correct order; check every wr_addr/wr_data against a software model of each pass, and that ties take the left run.
REQ-035 Hold out_ready=0 for 10 cycles on word 1 -> out_valid stays high and mergelist_out is unchanged; start pulses during busy are ignored.
REQ-036 Assert reset at MERGE pass 2, cycle 5 -> same cycle: wr_en=0, busy=0, out_valid=0; a fresh start then sorts a new list correctly.
